// File: rtl/score_tracker.sv
// BCD score keeper: synchronises asynchronous scoring events, adds 0-9 points per event with
// saturation at all-9s, tracks PLAYING/OVER state and keeps the best score since reset.
module score_tracker #(
    parameter int unsigned NUM_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    score_evt,
    input  logic [3:0]              points,
    input  logic                    new_game,
    input  logic                    game_over,
    output logic [4*NUM_DIGITS-1:0] score_bcd,
    output logic [4*NUM_DIGITS-1:0] high_bcd,
    output logic                    sat,
    output logic                    new_high
);

    localparam int unsigned W = 4 * NUM_DIGITS;
    localparam logic [W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

    localparam logic [0:0] ST_PLAYING = 1'b0;
    localparam logic [0:0] ST_OVER    = 1'b1;

    // Decimal ripple add of a single 0-9 value into digit 0; result MSB is the top-digit carry.
    function automatic logic [W:0] bcd_add(input logic [W-1:0] a, input logic [3:0] p);
        logic [4:0]   acc;
        logic [4:0]   addend;
        logic [W-1:0] sum;
        logic         carry;
        carry = 1'b0;
        sum   = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            addend = (i == 0) ? {1'b0, p} : {4'b0000, carry};
            acc    = {1'b0, a[4*i +: 4]} + addend;
            if (acc > 5'd9) begin
                acc   = acc - 5'd10;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            sum[4*i +: 4] = acc[3:0];
        end
        return {carry, sum};
    endfunction

    logic         sync_ff1_q;
    logic         sync_ff2_q;
    logic         sync_prev_q;
    logic         evt;

    logic [0:0]   state_q;
    logic [0:0]   state_d;
    logic [W-1:0] score_q;
    logic [W-1:0] score_d;
    logic [W-1:0] high_q;
    logic [W-1:0] high_d;
    logic         sat_q;
    logic         sat_d;
    logic         new_high_q;
    logic         new_high_d;

    logic [3:0]   pts_clamped;
    logic [W:0]   add_res;
    logic         add_carry;
    logic [W-1:0] add_sum;

    // Two-flop synchroniser plus edge detector: one evt cycle per rising edge of score_evt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_ff1_q  <= 1'b0;
            sync_ff2_q  <= 1'b0;
            sync_prev_q <= 1'b0;
        end else begin
            sync_ff1_q  <= score_evt;
            sync_ff2_q  <= sync_ff1_q;
            sync_prev_q <= sync_ff2_q;
        end
    end

    assign evt         = sync_ff2_q & ~sync_prev_q;
    assign pts_clamped = (points > 4'd9) ? 4'd9 : points;
    assign add_res     = bcd_add(score_q, pts_clamped);
    assign add_carry   = add_res[W];
    assign add_sum     = add_res[W-1:0];

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        high_d     = high_q;
        sat_d      = sat_q;
        new_high_d = 1'b0;

        if (new_game) begin
            state_d = ST_PLAYING;
            score_d = '0;
            sat_d   = 1'b0;
        end else if (game_over) begin
            if (state_q == ST_PLAYING) begin
                state_d = ST_OVER;
                if (score_q > high_q) begin
                    high_d     = score_q;
                    new_high_d = 1'b1;
                end
            end
        end else if (evt && (state_q == ST_PLAYING)) begin
            if (sat_q || add_carry || (add_sum == ALL_NINES)) begin
                score_d = ALL_NINES;
                sat_d   = 1'b1;
            end else begin
                score_d = add_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_PLAYING;
            score_q    <= '0;
            high_q     <= '0;
            sat_q      <= 1'b0;
            new_high_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            high_q     <= high_d;
            sat_q      <= sat_d;
            new_high_q <= new_high_d;
        end
    end

    assign score_bcd = score_q;
    assign high_bcd  = high_q;
    assign sat       = sat_q;
    assign new_high  = new_high_q;

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker: a 2-digit instance for most scenarios and a 3-digit one
// for the wider saturation case.
module tb_score_tracker;

    logic       clk;
    logic       rst;
    logic       score_evt;
    logic [3:0] points;
    logic       new_game;
    logic       game_over;
    logic [7:0] score_bcd;
    logic [7:0] high_bcd;
    logic       sat;
    logic       new_high;

    logic        evt3;
    logic [3:0]  pts3;
    logic        ng3;
    logic        go3;
    logic [11:0] score3;
    logic [11:0] high3;
    logic        sat3;
    logic        new_high3;

    int n_pass;
    int n_total;

    score_tracker #(.NUM_DIGITS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .score_evt (score_evt),
        .points    (points),
        .new_game  (new_game),
        .game_over (game_over),
        .score_bcd (score_bcd),
        .high_bcd  (high_bcd),
        .sat       (sat),
        .new_high  (new_high)
    );

    score_tracker #(.NUM_DIGITS(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .score_evt (evt3),
        .points    (pts3),
        .new_game  (ng3),
        .game_over (go3),
        .score_bcd (score3),
        .high_bcd  (high3),
        .sat       (sat3),
        .new_high  (new_high3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Full event: high 3 cycles (score updated by the end), then low 3 cycles.
    task automatic do_event(input logic [3:0] p);
        points    = p;
        score_evt = 1'b1;
        repeat (3) @(negedge clk);
        score_evt = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_event3(input logic [3:0] p);
        pts3 = p;
        evt3 = 1'b1;
        repeat (3) @(negedge clk);
        evt3 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_new_game;
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    task automatic pulse_game_over;
        game_over = 1'b1;
        @(negedge clk);
        game_over = 1'b0;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b0;
        score_evt = 1'b0;
        points    = 4'd0;
        new_game  = 1'b0;
        game_over = 1'b0;
        evt3      = 1'b0;
        pts3      = 4'd0;
        ng3       = 1'b0;
        go3       = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_score", score_bcd, 8'h00);
        check("rst_high", high_bcd, 8'h00);
        check("rst_sat", sat, 1'b0);
        check("rst_new_high", new_high, 1'b0);

        // Carry and latency: 0x19 + 3 appears on the 3rd edge.
        do_event(4'd9);
        do_event(4'd9);
        do_event(4'd1);
        check("build_19", score_bcd, 8'h19);
        points    = 4'd3;
        score_evt = 1'b1;
        @(negedge clk);
        check("lat_edge1", score_bcd, 8'h19);
        @(negedge clk);
        check("lat_edge2", score_bcd, 8'h19);
        @(negedge clk);
        check("lat_edge3", score_bcd, 8'h22);
        score_evt = 1'b0;
        repeat (3) @(negedge clk);

        // Held level is one event; 12 clamps to 9.
        pulse_new_game();
        check("ng_clear", score_bcd, 8'h00);
        points    = 4'd12;
        score_evt = 1'b1;
        repeat (10) @(negedge clk);
        score_evt = 1'b0;
        repeat (3) @(negedge clk);
        check("level_clamp", score_bcd, 8'h09);
        do_event(4'd0);
        check("points_zero", score_bcd, 8'h09);

        // Saturation by carry-out.
        pulse_new_game();
        for (int i = 0; i < 10; i++) do_event(4'd9);
        do_event(4'd5);
        check("build_95", score_bcd, 8'h95);
        check("sat_before", sat, 1'b0);
        do_event(4'd7);
        check("sat_score", score_bcd, 8'h99);
        check("sat_flag", sat, 1'b1);
        for (int i = 0; i < 3; i++) do_event(4'd1);
        check("sat_hold", score_bcd, 8'h99);
        check("sat_hold_flag", sat, 1'b1);
        pulse_new_game();
        check("sat_clr_score", score_bcd, 8'h00);
        check("sat_clr_flag", sat, 1'b0);

        // Exactly all-9s without carry-out.
        for (int i = 0; i < 10; i++) do_event(4'd9);
        check("build_90", score_bcd, 8'h90);
        check("sat_90", sat, 1'b0);
        do_event(4'd9);
        check("exact99", score_bcd, 8'h99);
        check("exact99_sat", sat, 1'b1);

        // High score: first game ends at 0x37.
        pulse_new_game();
        for (int i = 0; i < 4; i++) do_event(4'd9);
        do_event(4'd1);
        check("build_37", score_bcd, 8'h37);
        pulse_game_over();
        check("hs1_high", high_bcd, 8'h37);
        check("hs1_pulse", new_high, 1'b1);
        @(negedge clk);
        check("hs1_pulse_end", new_high, 1'b0);
        do_event(4'd5);
        check("over_ignore_evt", score_bcd, 8'h37);
        pulse_game_over();
        check("over_go_nopulse", new_high, 1'b0);

        // Equal and lower final scores leave the high score alone.
        pulse_new_game();
        for (int i = 0; i < 4; i++) do_event(4'd9);
        do_event(4'd1);
        pulse_game_over();
        check("hs_equal_high", high_bcd, 8'h37);
        check("hs_equal_pulse", new_high, 1'b0);
        pulse_new_game();
        check("ng_keeps_high", high_bcd, 8'h37);
        do_event(4'd9);
        do_event(4'd9);
        do_event(4'd2);
        check("build_20", score_bcd, 8'h20);
        pulse_game_over();
        check("hs_lower_high", high_bcd, 8'h37);
        check("hs_lower_pulse", new_high, 1'b0);

        // evt coincident with new_game is lost.
        pulse_new_game();
        do_event(4'd5);
        check("build_05", score_bcd, 8'h05);
        points    = 4'd4;
        score_evt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        check("evt_ng_score", score_bcd, 8'h00);
        @(negedge clk);
        score_evt = 1'b0;
        repeat (3) @(negedge clk);
        check("evt_ng_lost", score_bcd, 8'h00);

        // evt coincident with game_over is lost.
        do_event(4'd5);
        points    = 4'd4;
        score_evt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        game_over = 1'b1;
        @(negedge clk);
        game_over = 1'b0;
        score_evt = 1'b0;
        repeat (3) @(negedge clk);
        check("evt_go_lost", score_bcd, 8'h05);
        check("evt_go_high", high_bcd, 8'h37);

        // Three digits: 0x998 + 5 saturates.
        for (int i = 0; i < 110; i++) do_event3(4'd9);
        do_event3(4'd8);
        check("d3_build_998", score3, 12'h998);
        check("d3_sat_before", sat3, 1'b0);
        do_event3(4'd5);
        check("d3_sat_score", score3, 12'h999);
        check("d3_sat_flag", sat3, 1'b1);

        // Asynchronous reset mid-run, while new_high is pulsing.
        pulse_new_game();
        for (int i = 0; i < 4; i++) do_event(4'd9);
        do_event(4'd6);
        check("build_42", score_bcd, 8'h42);
        game_over = 1'b1;
        @(posedge clk);
        #1;
        game_over = 1'b0;
        check("pre_rst_high", high_bcd, 8'h42);
        check("pre_rst_pulse", new_high, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        check("async_score", score_bcd, 8'h00);
        check("async_high", high_bcd, 8'h00);
        check("async_sat", sat, 1'b0);
        check("async_new_high", new_high, 1'b0);
        check("async_d3_score", score3, 12'h000);
        check("async_d3_sat", sat3, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
